// File: rtl/serial_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serial_link_arbiter
// Function : Round-robin arbiter that serialises one requester word at a time
//            LSB-first, tagging each bit with its source and the final bit.
// Revision : 1.0 - initial release
// ============================================================================
module serial_link_arbiter #(
  parameter int n_req = 4,
  parameter int width = 8,
  parameter int id_w  = $clog2(n_req)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [n_req-1:0]       req_valid,
  input  logic [n_req*width-1:0] req_data,
  output logic [n_req-1:0]       req_ready,
  input  logic                   serial_ready,
  output logic                   serial_valid,
  output logic                   serial_data,
  output logic                   serial_last,
  output logic [id_w-1:0]        serial_src,
  output logic                   busy
);

  localparam int              c_CNT_W    = $clog2(width);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(width - 1);
  localparam logic [id_w-1:0]    c_PTR_RST  = id_w'(n_req - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [width-1:0]   r_shift;
  logic [id_w-1:0]    r_src;
  logic [id_w-1:0]    r_last_grant;

  logic               w_final;
  logic               w_allow;
  logic               w_found;
  logic               w_grant;
  logic [id_w-1:0]    w_gnt_idx;
  logic [width-1:0]   w_word;

  assign w_final = (r_state == SHIFT) && serial_ready && (r_cnt == c_CNT_LAST);
  assign w_allow = (r_state == IDLE) || w_final;
  // rst gates the grant so req_ready drops the moment reset is asserted.
  assign w_grant = rst && w_allow && w_found;

  // Searching from the farthest offset down lets the nearest valid requester win.
  always_comb begin : p_arb
    logic [id_w-1:0] v_idx;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    v_idx     = '0;
    for (int k = n_req; k >= 1; k--) begin
      v_idx = id_w'((int'(r_last_grant) + k) % n_req);
      if (req_valid[v_idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = v_idx;
      end
    end
  end

  always_comb begin : p_sel
    w_word    = '0;
    req_ready = '0;
    for (int i = 0; i < n_req; i++) begin
      if (w_gnt_idx == id_w'(i)) begin
        w_word       = req_data[i*width +: width];
        req_ready[i] = w_grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin : p_fsm
    w_state_nxt  = r_state;
    serial_valid = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        serial_valid = 1'b1;
        busy         = 1'b1;
        if (w_final && !w_grant) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_shift      <= '0;
      r_src        <= '0;
      r_last_grant <= c_PTR_RST;
    end else if (w_grant) begin
      r_shift      <= w_word;
      r_src        <= w_gnt_idx;
      r_last_grant <= w_gnt_idx;
      r_cnt        <= '0;
    end else if ((r_state == SHIFT) && serial_ready) begin
      if (w_final) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else begin
        r_shift <= r_shift >> 1;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  assign serial_data = (r_state == SHIFT) && r_shift[0];
  assign serial_last = (r_state == SHIFT) && (r_cnt == c_CNT_LAST);
  assign serial_src  = r_src;

endmodule
`default_nettype wire

// File: tb/tb_serial_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_link_arbiter
// Function : Directed bench for serial_link_arbiter with a word-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_link_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           serial_ready;
  logic           serial_valid;
  logic           serial_data;
  logic           serial_last;
  logic [1:0]     serial_src;
  logic           busy;

  logic           rst2;
  logic [1:0]     rv2;
  logic [31:0]    rd2;
  logic [1:0]     rr2;
  logic           sr2;
  logic           sv2;
  logic           sd2;
  logic           sl2;
  logic [0:0]     src2;
  logic           busy2;

  serial_link_arbiter #(.n_req(N), .width(W)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .serial_ready(serial_ready), .serial_valid(serial_valid),
    .serial_data(serial_data), .serial_last(serial_last), .serial_src(serial_src),
    .busy(busy)
  );

  serial_link_arbiter #(.n_req(2), .width(16)) u_dut2 (
    .clk(clk), .rst(rst2), .req_valid(rv2), .req_data(rd2),
    .req_ready(rr2), .serial_ready(sr2), .serial_valid(sv2),
    .serial_data(sd2), .serial_last(sl2), .serial_src(src2),
    .busy(busy2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int xfer  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  int quota[N];
  int taken[N];
  int gq[$];
  int gcyc[$];
  int lcyc[$];
  int sq[$];
  logic [W-1:0] wq[$];
  logic [W-1:0] asm_w;
  int abit;

  // Word-level reference: which word is on the wire and which bit of it.
  bit           m_busy;
  logic [W-1:0] m_word;
  int           m_bit;
  int           m_src;
  int           m_ptr;
  logic         e_valid, e_data, e_last, allow;
  logic [N-1:0] e_ready;
  int           g;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check("rst_valid", serial_valid, 0);
      check("rst_ready", req_ready, 0);
      check("rst_busy", busy, 0);
      m_busy = 0; m_bit = 0; m_src = 0; m_ptr = N - 1; m_word = '0;
      abit = 0; asm_w = '0;
    end else begin
      e_valid = m_busy;
      e_data  = m_busy ? m_word[m_bit] : 1'b0;
      e_last  = m_busy && (m_bit == W - 1);
      allow   = !m_busy || (e_last && serial_ready);
      g = -1;
      for (int k = 1; k <= N; k++)
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      e_ready = '0;
      if (allow && g >= 0) e_ready[g] = 1'b1;
      check("serial_valid", serial_valid, e_valid);
      check("serial_data", serial_data, e_data);
      check("serial_last", serial_last, e_last);
      check("serial_src", serial_src, m_src);
      check("busy", busy, e_valid);
      check("req_ready", req_ready, e_ready);

      for (int i = 0; i < N; i++)
        if (req_ready[i]) begin taken[i]++; gq.push_back(i); gcyc.push_back(cyc); end
      if (serial_valid && serial_ready) begin
        xfer++;
        if (abit < W) asm_w[abit] = serial_data;
        abit++;
        if (serial_last) begin
          wq.push_back(asm_w); sq.push_back(int'(serial_src)); lcyc.push_back(cyc);
          abit = 0;
        end
      end

      if (m_busy && serial_ready) begin
        if (m_bit == W - 1) m_busy = 0; else m_bit++;
      end
      if (allow && g >= 0) begin
        m_busy = 1; m_word = req_data[g*W +: W]; m_bit = 0; m_src = g; m_ptr = g;
      end
    end
  end

  logic [15:0] wq2[$];
  int          sq2[$];
  int          lc2[$];
  logic [15:0] asm2;
  int          abit2 = 0;
  int          cur_src2 = 0;

  always @(negedge clk) begin
    if (rst2 && sv2 && sr2) begin
      if (abit2 == 0) cur_src2 = int'(src2);
      else check("src2_stable", src2, cur_src2);
      if (abit2 < 16) asm2[abit2] = sd2;
      abit2++;
      if (sl2) begin
        wq2.push_back(asm2); sq2.push_back(int'(src2)); lc2.push_back(cyc);
        abit2 = 0;
      end
    end
  end

  bit stall = 0;
  int bp_cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) req_valid[i] = (taken[i] < quota[i]);
    if (stall) begin
      serial_ready = (bp_cnt % 4 == 0) || (bp_cnt % 4 == 3);
      bp_cnt++;
    end else begin
      serial_ready = 1'b1;
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (taken[i] < quota[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_until_idle(input int budget, input string name);
    int n = 0;
    do begin step(); n++; end while ((pending() || busy) && n < budget);
    check({name, "_timeout"}, n < budget, 1);
  endtask

  task automatic clear_logs();
    gq.delete(); gcyc.delete(); lcyc.delete(); sq.delete(); wq.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int x0;
    int n;
    rst = 0; req_valid = '0; req_data = '0; serial_ready = 1'b1;
    rst2 = 0; rv2 = '0; rd2 = {16'h1234, 16'hBEEF}; sr2 = 1'b1;
    for (int i = 0; i < N; i++) begin quota[i] = 0; taken[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", serial_valid, 0);
    check("reset_data", serial_data, 0);
    check("reset_last", serial_last, 0);
    check("reset_src", serial_src, 0);
    check("reset_busy", busy, 0);
    check("reset_ready", req_ready, 0);
    rst = 1;

    // Single word 8'hA5 from requester 0.
    req_data[7:0] = 8'hA5;
    quota[0]++;
    run_until_idle(40, "single");
    check("single_count", wq.size(), 1);
    check("single_word", wq[0], 8'hA5);
    check("single_src", sq[0], 0);
    check("single_grant", gq[0], 0);
    check("single_latency", lcyc[0] - gcyc[0], 8);
    check("single_busy_after", busy, 0);

    // Fairness from a fresh pointer.
    rst = 0; step(); rst = 1;
    clear_logs();
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    for (int i = 0; i < N; i++) quota[i]++;
    run_until_idle(80, "fair");
    check("fair_count", wq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("fair_grant", gq[i], i);
      check("fair_src", sq[i], i);
    end
    check("fair_w0", wq[0], 8'h10);
    check("fair_w3", wq[3], 8'h43);
    check("fair_span", lcyc[3] - gcyc[0], 32);

    // Pointer at 3: requesters 1 and 2 only.
    clear_logs();
    req_data[15:8] = 8'h5A; req_data[23:16] = 8'h66;
    quota[1]++; quota[2]++;
    run_until_idle(60, "wrap");
    check("wrap_g0", gq[0], 1);
    check("wrap_g1", gq[1], 2);
    check("wrap_w0", wq[0], 8'h5A);
    check("wrap_w1", wq[1], 8'h66);

    // Back-pressure on 8'hC3, with requester 1 waiting behind it.
    clear_logs();
    req_data[7:0] = 8'hC3; req_data[15:8] = 8'h3C;
    stall = 1; bp_cnt = 0;
    quota[0]++; quota[1]++;
    run_until_idle(200, "bp");
    stall = 0;
    check("bp_grants", gq.size(), 2);
    check("bp_g0", gq[0], 0);
    check("bp_g1", gq[1], 1);
    check("bp_w0", wq[0], 8'hC3);
    check("bp_w1", wq[1], 8'h3C);
    check("bp_regrant_at_final", gcyc[1], lcyc[0]);

    // Reset after bit 3 of a word from requester 2.
    clear_logs();
    req_data[23:16] = 8'h96;
    quota[2]++;
    x0 = xfer; n = 0;
    do begin step(); n++; end while (xfer - x0 < 4 && n < 40);
    check("midrst_timeout", n < 40, 1);
    check("midrst_busy_before", busy, 1);
    #2;
    rst = 0;
    #1;
    check("midrst_valid", serial_valid, 0);
    check("midrst_data", serial_data, 0);
    check("midrst_last", serial_last, 0);
    check("midrst_src", serial_src, 0);
    check("midrst_busy", busy, 0);
    step(); step();
    check("midrst_no_word", wq.size(), 0);
    clear_logs();
    quota[2]++; quota[0]++;
    rst = 1;
    run_until_idle(60, "midrst");
    check("midrst_g0", gq[0], 0);
    check("midrst_g1", gq[1], 2);
    check("midrst_words", wq.size(), 2);
    check("midrst_w0", wq[0], 8'hC3);
    check("midrst_w1", wq[1], 8'h96);

    // Two requesters, 16-bit words.
    step();
    rst2 = 1; rv2 = 2'b11;
    n = 0;
    while (wq2.size() < 4 && n < 200) begin step(); n++; end
    rv2 = 2'b00;
    check("p2_timeout", n < 200, 1);
    check("p2_w0", wq2[0], 16'hBEEF);
    check("p2_w1", wq2[1], 16'h1234);
    check("p2_w2", wq2[2], 16'hBEEF);
    check("p2_w3", wq2[3], 16'h1234);
    for (int i = 0; i < 4; i++) check("p2_src", sq2[i], i % 2);
    check("p2_span", lc2[3] - lc2[0], 48);

    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
